// File: rtl/arrow_judge.sv
// arrow_judge: judges pad presses against the arrow sitting in the hit slot.
// Each metronome beat opens a fresh judging window on the new hit-slot arrow.
// A window closes as PERFECT or GOOD once every arrow direction has been
// pressed. It closes as MISS on a wrong press, or when the next beat arrives
// first. Results drive a one-cycle valid pulse, a saturating score and a combo.
// Optional feature macro: COMBO_BONUS_EN doubles hit points while combo >= 10.

module arrow_judge #(
    parameter int ARROW_W     = 4,
    parameter int CNT_W       = 24,
    parameter int PERFECT_CYC = 2500000,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               beat_tick,
    input  logic [ARROW_W-1:0] target_arrow,
    input  logic [ARROW_W-1:0] btn,
    output logic               judge_valid,
    output logic [1:0]         judge,
    output logic [15:0]        score,
    output logic [7:0]         combo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PERFECT = 2'd1,
        RES_GOOD    = 2'd2,
        RES_MISS    = 2'd3
    } result_t;

    localparam logic [CNT_W-1:0] PERFECT_LIM = CNT_W'(PERFECT_CYC);
    localparam logic [15:0]      PERFECT_P16 = 16'(PERFECT_PTS);
    localparam logic [15:0]      GOOD_P16    = 16'(GOOD_PTS);

    state_t             state_q, state_d;
    logic [ARROW_W-1:0] tgt_q, tgt_d;
    logic [ARROW_W-1:0] got_q, got_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ARROW_W-1:0] btn_q;
    logic               valid_q, valid_d;
    result_t            judge_q, judge_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         combo_q, combo_d;

    logic [ARROW_W-1:0] press;
    result_t            result;
    logic               reopen;
    logic [15:0]        pts;
    logic [16:0]        sum17;

    // Window decision, reopen handling and score/combo bookkeeping for this cycle
    always_comb begin
        press   = btn & ~btn_q;
        result  = RES_NONE;
        reopen  = 1'b0;
        state_d = state_q;
        tgt_d   = tgt_q;
        got_d   = got_q;
        cnt_d   = cnt_q;
        pts     = 16'd0;
        sum17   = 17'd0;

        case (state_q)
            WINDOW: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                got_d = got_q | press;
                if ((press & ~tgt_q) != '0) begin
                    result  = RES_MISS;
                    state_d = DONE;
                end else if ((got_q | press) == tgt_q) begin
                    result  = (cnt_q < PERFECT_LIM) ? RES_PERFECT : RES_GOOD;
                    state_d = DONE;
                end else if (beat_tick) begin
                    result = RES_MISS;
                end
                reopen = beat_tick;
            end
            IDLE:    reopen = beat_tick;
            DONE:    reopen = beat_tick;
            default: state_d = IDLE;
        endcase

        // A beat always starts the next window; the press above already judged the old one
        if (reopen) begin
            if (target_arrow != '0) begin
                state_d = WINDOW;
                tgt_d   = target_arrow;
                got_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end

        valid_d = (result != RES_NONE);
        judge_d = valid_d ? result : judge_q;
        score_d = score_q;
        combo_d = combo_q;

        if (result == RES_PERFECT || result == RES_GOOD) begin
            pts = (result == RES_PERFECT) ? PERFECT_P16 : GOOD_P16;
`ifdef COMBO_BONUS_EN
            if (combo_q >= 8'd10) begin
                pts = pts << 1;
            end
`endif
            sum17   = 17'(score_q) + 17'(pts);
            score_d = sum17[16] ? 16'hFFFF : sum17[15:0];
            combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        end else if (result == RES_MISS) begin
            combo_d = 8'd0;
        end
    end

    // All state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            got_q   <= '0;
            cnt_q   <= '0;
            btn_q   <= '0;
            valid_q <= 1'b0;
            judge_q <= RES_NONE;
            score_q <= 16'd0;
            combo_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            got_q   <= got_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn;
            valid_q <= valid_d;
            judge_q <= judge_d;
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign judge_valid = valid_q;
    assign judge       = judge_q;
    assign score       = score_q;
    assign combo       = combo_q;

endmodule

// File: tb/tb_arrow_judge.sv
// Testbench for arrow_judge: directed vector table, scripted multi-cycle
// sequences and randomized stimulus checked against a behavioural model.
// Optional feature macro: COMBO_BONUS_EN (must match the DUT build).

module tb_arrow_judge;

    localparam int PCYC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       beat_tick;
    logic [3:0] target_arrow;
    logic [3:0] btn;
    logic       judge_valid;
    logic [1:0] judge;
    logic [15:0] score;
    logic [7:0] combo;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [3:0] mBtnPrev;
    bit         mOpen;
    bit         mJudged;
    logic [3:0] mTgt;
    logic [3:0] mGot;
    int         mAge;
    bit         mValid;
    int         mJudge;
    int         mScore;
    int         mCombo;

    typedef struct {
        logic       beat;
        logic [3:0] tgt;
        logic [3:0] btnv;
        logic       expValid;
        logic [1:0] expJudge;
        logic [15:0] expScore;
        logic [7:0] expCombo;
    } vec_t;

    vec_t vecQ[$];

    arrow_judge #(
        .ARROW_W    (4),
        .CNT_W      (24),
        .PERFECT_CYC(PCYC),
        .PERFECT_PTS(3),
        .GOOD_PTS   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_tick   (beat_tick),
        .target_arrow(target_arrow),
        .btn         (btn),
        .judge_valid (judge_valid),
        .judge       (judge),
        .score       (score),
        .combo       (combo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic modelReset();
        mBtnPrev = 4'd0;
        mOpen    = 0;
        mJudged  = 0;
        mTgt     = 4'd0;
        mGot     = 4'd0;
        mAge     = 0;
        mValid   = 0;
        mJudge   = 0;
        mScore   = 0;
        mCombo   = 0;
    endtask

    // One clock of the game rules: judge the live window, then let a beat open the next one
    task automatic modelStep(input logic beat, input logic [3:0] tgt, input logic [3:0] b);
        logic [3:0] press;
        int res;
        int pts;
        press    = b & ~mBtnPrev;
        mBtnPrev = b;
        res      = 0;
        if (mOpen && !mJudged) begin
            if ((press & ~mTgt) != 4'd0) res = 3;
            else if ((mGot | press) == mTgt) res = (mAge < PCYC) ? 1 : 2;
            else if (beat) res = 3;
            mGot = mGot | press;
            mAge = mAge + 1;
            if (res != 0) mJudged = 1;
        end
        if (beat) begin
            if (tgt != 4'd0) begin
                mOpen   = 1;
                mJudged = 0;
                mTgt    = tgt;
                mGot    = 4'd0;
                mAge    = 0;
            end else begin
                mOpen = 0;
            end
        end
        mValid = (res != 0);
        if (res != 0) begin
            mJudge = res;
            if (res == 3) begin
                mCombo = 0;
            end else begin
                pts = (res == 1) ? 3 : 1;
`ifdef COMBO_BONUS_EN
                if (mCombo >= 10) pts = pts * 2;
`endif
                mScore = (mScore + pts > 65535) ? 65535 : mScore + pts;
                mCombo = (mCombo + 1 > 255) ? 255 : mCombo + 1;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and sample just after the rising edge
    task automatic applyStimulus(input logic beat, input logic [3:0] tgt, input logic [3:0] b);
        @(negedge clk);
        beat_tick    = beat;
        target_arrow = tgt;
        btn          = b;
        modelStep(beat, tgt, b);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [1:0] j,
                               input logic [15:0] s, input logic [7:0] c);
        checks += 4;
        if (judge_valid !== v) begin
            errors++;
            $display("[TB] FAIL %s judge_valid got %0b want %0b", name, judge_valid, v);
        end
        if (judge !== j) begin
            errors++;
            $display("[TB] FAIL %s judge got %0d want %0d", name, judge, j);
        end
        if (score !== s) begin
            errors++;
            $display("[TB] FAIL %s score got %0d want %0d", name, score, s);
        end
        if (combo !== c) begin
            errors++;
            $display("[TB] FAIL %s combo got %0d want %0d", name, combo, c);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mValid, mJudge[1:0], 16'(mScore), 8'(mCombo));
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        beat_tick    = 1'b0;
        target_arrow = 4'd0;
        btn          = 4'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 2'd0, 16'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic addVec(input logic beat, input logic [3:0] tgt, input logic [3:0] b,
                          input logic ev, input logic [1:0] ej, input logic [15:0] es,
                          input logic [7:0] ec);
        vec_t v;
        v.beat = beat; v.tgt = tgt; v.btnv = b;
        v.expValid = ev; v.expJudge = ej; v.expScore = es; v.expCombo = ec;
        vecQ.push_back(v);
    endtask

    // Directed table, then bonus/saturation/async-reset sequences, then random run
    initial begin
        logic [3:0] curBtn;
        logic       rb;
        logic [3:0] rt;
        logic [15:0] expBonus;

        // Single-arrow PERFECT two cycles after the beat
        addVec(1, 4'b0010, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        addVec(0, 4'b0000, 4'b0010, 1, 1, 3, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 3, 1);
        // Chord: partial press, completed late -> single GOOD
        addVec(1, 4'b1001, 4'b0000, 0, 1, 3, 1);
        for (int i = 0; i < 7; i++) addVec(0, 4'b0000, 4'b1000, 0, 1, 3, 1);
        addVec(0, 4'b0000, 4'b1001, 1, 2, 4, 2);
        addVec(0, 4'b0000, 4'b0000, 0, 2, 4, 2);
        // Wrong direction -> immediate MISS, later correct press ignored
        addVec(1, 4'b0100, 4'b0000, 0, 2, 4, 2);
        addVec(0, 4'b0000, 4'b0001, 1, 3, 4, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 3, 4, 0);
        addVec(0, 4'b0000, 4'b0100, 0, 3, 4, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 3, 4, 0);
        // Unpressed arrow missed by next beat, new window immediately live
        addVec(1, 4'b0001, 4'b0000, 0, 3, 4, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 3, 4, 0);
        addVec(1, 4'b0010, 4'b0000, 1, 3, 4, 0);
        addVec(0, 4'b0000, 4'b0010, 1, 1, 7, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 7, 1);
        // Completing press on the beat judges the old window; the new one is live
        addVec(1, 4'b0100, 4'b0000, 0, 1, 7, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 7, 1);
        addVec(1, 4'b1000, 4'b0100, 1, 1, 10, 2);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 10, 2);
        addVec(0, 4'b0000, 4'b1000, 1, 1, 13, 3);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 13, 3);
        // Beat with empty slot from DONE: idle, presses ignored
        addVec(1, 4'b0000, 4'b0000, 0, 1, 13, 3);
        addVec(0, 4'b0000, 4'b0001, 0, 1, 13, 3);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 13, 3);
        // Empty-slot beat during an open window -> MISS then idle
        addVec(1, 4'b0010, 4'b0000, 0, 1, 13, 3);
        addVec(1, 4'b0000, 4'b0000, 1, 3, 13, 0);
        addVec(0, 4'b0000, 4'b0010, 0, 3, 13, 0);
        addVec(0, 4'b0000, 4'b0000, 0, 3, 13, 0);
        // Boundary: completion at count 3 is PERFECT, at count 4 is GOOD
        addVec(1, 4'b0001, 4'b0000, 0, 3, 13, 0);
        for (int i = 0; i < 3; i++) addVec(0, 4'b0000, 4'b0000, 0, 3, 13, 0);
        addVec(0, 4'b0000, 4'b0001, 1, 1, 16, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 1, 16, 1);
        addVec(1, 4'b0001, 4'b0000, 0, 1, 16, 1);
        for (int i = 0; i < 4; i++) addVec(0, 4'b0000, 4'b0000, 0, 1, 16, 1);
        addVec(0, 4'b0000, 4'b0001, 1, 2, 17, 2);
        addVec(0, 4'b0000, 4'b0000, 0, 2, 17, 2);

        doReset();
        foreach (vecQ[i]) begin
            applyStimulus(vecQ[i].beat, vecQ[i].tgt, vecQ[i].btnv);
            checkOutput($sformatf("vec%0d", i), vecQ[i].expValid, vecQ[i].expJudge,
                        vecQ[i].expScore, vecQ[i].expCombo);
        end

        // Ten quick PERFECT hits, then the 11th shows whether the combo bonus applies
        doReset();
        applyStimulus(1, 4'b0001, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 4'b0000, 4'b0000);
            applyStimulus(1, 4'b0001, 4'b0001);
        end
        checkOutput("tenHits", 1'b1, 2'd1, 16'd30, 8'd10);
        applyStimulus(0, 4'b0000, 4'b0000);
        applyStimulus(1, 4'b0001, 4'b0001);
`ifdef COMBO_BONUS_EN
        expBonus = 16'd36;
`else
        expBonus = 16'd33;
`endif
        checkOutput("eleventhHit", 1'b1, 2'd1, expBonus, 8'd11);

        // Drive score into saturation with back-to-back hits
        for (int i = 0; i < 22000; i++) begin
            applyStimulus(0, 4'b0000, 4'b0000);
            checkModel("satIdle");
            applyStimulus(1, 4'b0001, 4'b0001);
            checkModel("satHit");
        end
        checkOutput("saturated", 1'b1, 2'd1, 16'hFFFF, 8'hFF);

        // Asynchronous reset in the middle of a live window
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 1'b0, 2'd0, 16'd0, 8'd0);
        modelReset();
        beat_tick    = 1'b0;
        target_arrow = 4'd0;
        btn          = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized play against the model
        curBtn = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            rb = ($urandom_range(0, 4) == 0);
            rt = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) curBtn = curBtn ^ 4'(1 << $urandom_range(0, 3));
            applyStimulus(rb, rt, curBtn);
            checkModel($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
